// File: rtl/updtxsch_if.sv
// Bundle between the USBPD transmit scheduler and its MCU, protocol-layer, PHY-RX and PHY-TX peers.
// The master modport drives the requests; the slave modport is the scheduler itself.
interface updtxsch_if;
  logic       r_txreq;
  logic [1:0] r_retry;
  logic       r_txnogdcrc;
  logic       prl_idle;
  logic       prl_txreq;
  logic       pid_ccidle;
  logic       prx_gdcrcrcvd;
  logic       prx_msgrcvd;
  logic       ptx_ack;
  logic       sch_txreq;
  logic       sch_sel;
  logic       sch_busy;
  logic       sch_txdone;
  logic       sch_txfail;
  logic       sch_txdisc;
  logic [1:0] sch_retrycnt;
  logic [2:0] sch_fsm;

  modport master (
    output r_txreq, r_retry, r_txnogdcrc, prl_idle, prl_txreq, pid_ccidle,
           prx_gdcrcrcvd, prx_msgrcvd, ptx_ack,
    input  sch_txreq, sch_sel, sch_busy, sch_txdone, sch_txfail, sch_txdisc,
           sch_retrycnt, sch_fsm
  );

  modport slave (
    input  r_txreq, r_retry, r_txnogdcrc, prl_idle, prl_txreq, pid_ccidle,
           prx_gdcrcrcvd, prx_msgrcvd, ptx_ack,
    output sch_txreq, sch_sel, sch_busy, sch_txdone, sch_txfail, sch_txdisc,
           sch_retrycnt, sch_fsm
  );
endinterface

// File: rtl/updtxsch.sv
// USBPD transmit scheduler: arbitrates PHY-TX between MCU messages and protocol-layer responses,
// and runs the MCU message through CC-idle wait, transmit, GoodCRC wait and retries.
module updtxsch #(
  parameter int unsigned CRCTO_CYC = 11000,
  parameter int unsigned TMR_W     = 14
) (
  input logic        clk_i,
  input logic        srst_i,
  updtxsch_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRL  = 3'd1,
    S_WIDL = 3'd2,
    S_MTX  = 3'd3,
    S_WCRC = 3'd4
  } state_e;

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CRCTO_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [1:0]       retry_q, retry_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             txreq_q, txreq_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             disc_q, disc_d;
  logic             busy;
  logic             accept;

  // A pending request counts as busy even during the one IDLE cycle before it resumes.
  assign busy   = pend_q | (state_q == S_WIDL) | (state_q == S_MTX) | (state_q == S_WCRC);
  assign accept = bus.r_txreq & ~busy;

  // State and status registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      retry_q <= 2'd0;
      tmr_q   <= TMR_ZERO;
      txreq_q <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      disc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      retry_q <= retry_d;
      tmr_q   <= tmr_d;
      txreq_q <= txreq_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      disc_q  <= disc_d;
    end
  end

  // Next-state and status-pulse decode.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    retry_d = retry_q;
    tmr_d   = tmr_q;
    txreq_d = 1'b0;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    disc_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.prl_idle) begin
          state_d = S_PRL;
          pend_d  = pend_q | accept;
          retry_d = accept ? 2'd0 : retry_q;
        end else if (accept || pend_q) begin
          state_d = S_WIDL;
          pend_d  = 1'b0;
          retry_d = accept ? 2'd0 : retry_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRL: begin
        pend_d  = pend_q | accept;
        retry_d = accept ? 2'd0 : retry_q;
        if (bus.prl_idle) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PRL;
        end
      end
      S_WIDL: begin
        if (bus.prx_msgrcvd) begin
          state_d = S_IDLE;
          disc_d  = 1'b1;
          pend_d  = 1'b0;
        end else if (!bus.prl_idle) begin
          state_d = S_PRL;
          pend_d  = 1'b1;
        end else if (bus.pid_ccidle) begin
          state_d = S_MTX;
          txreq_d = 1'b1;
        end else begin
          state_d = S_WIDL;
        end
      end
      S_MTX: begin
        if (bus.ptx_ack && bus.r_txnogdcrc) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (bus.ptx_ack) begin
          state_d = S_WCRC;
          tmr_d   = TMR_LOAD;
        end else begin
          state_d = S_MTX;
        end
      end
      S_WCRC: begin
        if (bus.prx_gdcrcrcvd) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (bus.prx_msgrcvd) begin
          state_d = S_IDLE;
          disc_d  = 1'b1;
        end else if (tmr_q == TMR_ZERO) begin
          // >= rather than == so a lowered r_retry still terminates.
          if (retry_q >= bus.r_retry) begin
            state_d = S_IDLE;
            fail_d  = 1'b1;
          end else begin
            state_d = S_WIDL;
            retry_d = (retry_q == 2'd3) ? 2'd3 : (retry_q + 2'd1);
          end
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end
    endcase
  end

  assign bus.sch_txreq    = (state_q == S_PRL) ? bus.prl_txreq : txreq_q;
  assign bus.sch_sel      = (state_q == S_PRL);
  assign bus.sch_busy     = busy;
  assign bus.sch_txdone   = done_q;
  assign bus.sch_txfail   = fail_q;
  assign bus.sch_txdisc   = disc_q;
  assign bus.sch_retrycnt = retry_q;
  assign bus.sch_fsm      = state_q;

endmodule

// File: tb/tb_updtxsch.sv
// Bench for updtxsch: a timestamp model predicts each MCU TX pulse, status pulse,
// GoodCRC-wait duration and final retry count from the scheduling rules.
module tb_updtxsch;
  localparam int CRCTO = 700;

  logic clk = 1'b0;
  logic srst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_tx = 0, n_done = 0, n_fail = 0, n_disc = 0, n_wcrc = 0, n_wide = 0;
  int   last_tx = 0, last_done = 0, last_fail = 0, last_disc = 0;
  bit   p_tx, p_done, p_fail, p_disc;

  updtxsch_if bus();

  updtxsch #(.CRCTO_CYC(CRCTO), .TMR_W(10)) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts and timestamps pulses on the falling edge.
  always @(negedge clk) begin
    bit mtx;
    mtx = (bus.sch_txreq === 1'b1) && (bus.sch_sel === 1'b0);
    if (mtx) begin n_tx++; last_tx = cyc; end
    if (bus.sch_txdone === 1'b1) begin n_done++; last_done = cyc; end
    if (bus.sch_txfail === 1'b1) begin n_fail++; last_fail = cyc; end
    if (bus.sch_txdisc === 1'b1) begin n_disc++; last_disc = cyc; end
    if (bus.sch_fsm === 3'd4) n_wcrc++;
    if ((mtx && p_tx) || (bus.sch_txdone === 1'b1 && p_done) ||
        (bus.sch_txfail === 1'b1 && p_fail) || (bus.sch_txdisc === 1'b1 && p_disc))
      n_wide++;
    p_tx   = mtx;
    p_done = (bus.sch_txdone === 1'b1);
    p_fail = (bus.sch_txfail === 1'b1);
    p_disc = (bus.sch_txdisc === 1'b1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
    n_vec++;
    if (obs !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int evt_cnt(input int kind);
    case (kind)
      0: return n_tx;
      1: return n_done;
      2: return n_fail;
      3: return n_disc;
      default: return 0;
    endcase
  endfunction

  function automatic int last_of(input int kind);
    case (kind)
      0: return last_tx;
      1: return last_done;
      2: return last_fail;
      3: return last_disc;
      default: return -1;
    endcase
  endfunction

  task automatic wait_evt(input string tag, input int kind, input int target, input int bound);
    int k;
    k = 0;
    while (evt_cnt(kind) < target && k < bound) begin
      tick();
      k++;
    end
    check_val(tag, evt_cnt(kind), target);
  endtask

  // mode 0: GoodCRC after nfail timeouts, 1: retries exhausted,
  //      2: message received after nfail timeouts, 3: no GoodCRC expected.
  task automatic run_txn(input string tag, input int retry, input int mode, input int nfail,
                         input int ccw, input int ackd, input int respd);
    int tx0, st0, w0, o0, att_n, exp_rc, out_kind, exp_tx, exp_out, exp_w, a;
    tx0      = n_tx;
    st0      = n_done + n_fail + n_disc;
    w0       = n_wcrc;
    att_n    = (mode == 1) ? retry + 1 : ((mode == 3) ? 1 : nfail + 1);
    exp_rc   = (mode == 1) ? retry : ((mode == 3) ? 0 : nfail);
    out_kind = (mode == 1) ? 2 : ((mode == 2) ? 3 : 1);
    o0       = evt_cnt(out_kind);
    exp_w    = 0;
    exp_out  = 0;
    bus.r_retry     = 2'(retry);
    bus.r_txnogdcrc = (mode == 3);
    bus.pid_ccidle  = (ccw == 0);
    bus.r_txreq     = 1'b1;
    exp_tx = cyc + ((ccw + 1 > 2) ? ccw + 1 : 2);
    tick();
    bus.r_txreq = 1'b0;
    if (ccw > 0) begin
      repeat (ccw - 1) tick();
      bus.pid_ccidle = 1'b1;
    end
    for (int i = 0; i < att_n; i++) begin
      wait_evt({tag, "_tx"}, 0, tx0 + i + 1, CRCTO + 20);
      check_val({tag, "_txcyc"}, last_tx, exp_tx);
      repeat (ackd) tick();
      bus.ptx_ack = 1'b1;
      a = cyc;
      tick();
      bus.ptx_ack = 1'b0;
      if (mode == 3) begin
        exp_out = a + 1;
      end else if (i == att_n - 1 && mode != 1) begin
        repeat (respd - 1) tick();
        if (mode == 0) bus.prx_gdcrcrcvd = 1'b1;
        else           bus.prx_msgrcvd   = 1'b1;
        exp_out = cyc + 1;
        exp_w  += respd;
        tick();
        bus.prx_gdcrcrcvd = 1'b0;
        bus.prx_msgrcvd   = 1'b0;
      end else begin
        exp_tx  = a + CRCTO + 2;
        exp_out = a + CRCTO + 1;
        exp_w  += CRCTO;
      end
    end
    wait_evt({tag, "_out"}, out_kind, o0 + 1, CRCTO + 20);
    check_val({tag, "_outcyc"}, last_of(out_kind), exp_out);
    repeat (4) tick();
    check_val({tag, "_ntx"}, n_tx - tx0, att_n);
    check_val({tag, "_nstatus"}, n_done + n_fail + n_disc - st0, 1);
    check_val({tag, "_wcrc"}, n_wcrc - w0, exp_w);
    check_val({tag, "_retrycnt"}, bus.sch_retrycnt, exp_rc);
    check_val({tag, "_fsm"}, bus.sch_fsm, 0);
    check_val({tag, "_busy"}, bus.sch_busy, 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: observed no end expected end");
    $fatal(1);
  end

  initial begin
    int tx0, s0, a, p, st, md, rt;
    srst              = 1'b1;
    bus.r_txreq       = 1'b0;
    bus.r_retry       = 2'd0;
    bus.r_txnogdcrc   = 1'b0;
    bus.prl_idle      = 1'b1;
    bus.prl_txreq     = 1'b0;
    bus.pid_ccidle    = 1'b1;
    bus.prx_gdcrcrcvd = 1'b0;
    bus.prx_msgrcvd   = 1'b0;
    bus.ptx_ack       = 1'b0;
    repeat (3) tick();
    check_val("rst_fsm", bus.sch_fsm, 0);
    check_val("rst_busy", bus.sch_busy, 0);
    check_val("rst_retrycnt", bus.sch_retrycnt, 0);
    check_val("rst_outs", {bus.sch_txreq, bus.sch_sel, bus.sch_txdone, bus.sch_txfail, bus.sch_txdisc}, 0);
    srst = 1'b0;
    tick();

    run_txn("succ", 2, 0, 0, 0, 3, 100);
    run_txn("exh", 2, 1, 0, 0, 2, 0);
    run_txn("nogd", 0, 3, 0, 0, 1, 0);
    run_txn("coin", 1, 0, 0, 0, 0, CRCTO);
    run_txn("discw", 3, 2, 1, 0, 1, 50);

    // Discard while waiting for CC idle.
    tx0 = n_tx;
    s0  = n_disc;
    bus.pid_ccidle = 1'b0;
    bus.r_txreq    = 1'b1;
    tick();
    bus.r_txreq = 1'b0;
    tick();
    tick();
    check_val("widl_fsm", bus.sch_fsm, 2);
    bus.prx_msgrcvd = 1'b1;
    a = cyc;
    tick();
    bus.prx_msgrcvd = 1'b0;
    wait_evt("widl_disc", 3, s0 + 1, 10);
    check_val("widl_disccyc", last_disc, a + 1);
    bus.pid_ccidle = 1'b1;
    repeat (5) tick();
    check_val("widl_notx", n_tx - tx0, 0);
    check_val("widl_fsm_end", bus.sch_fsm, 0);

    // Protocol layer wins over a same-cycle MCU request.
    tx0 = n_tx;
    s0  = n_done;
    bus.r_txnogdcrc = 1'b1;
    bus.prl_idle    = 1'b0;
    bus.r_txreq     = 1'b1;
    tick();
    bus.r_txreq = 1'b0;
    check_val("arb_fsm", bus.sch_fsm, 1);
    check_val("arb_sel", bus.sch_sel, 1);
    check_val("arb_busy", bus.sch_busy, 1);
    bus.prl_txreq = 1'b1;
    #1;
    check_val("arb_pass_hi", bus.sch_txreq, 1);
    bus.prl_txreq = 1'b0;
    #1;
    check_val("arb_pass_lo", bus.sch_txreq, 0);
    tick();
    tick();
    check_val("arb_hold_fsm", bus.sch_fsm, 1);
    bus.prl_idle = 1'b1;
    p = cyc;
    wait_evt("arb_tx", 0, tx0 + 1, 20);
    check_val("arb_txcyc", last_tx, p + 3);
    check_val("arb_mcu_sel", bus.sch_sel, 0);
    bus.ptx_ack = 1'b1;
    a = cyc;
    tick();
    bus.ptx_ack = 1'b0;
    wait_evt("arb_done", 1, s0 + 1, 20);
    check_val("arb_donecyc", last_done, a + 1);
    bus.r_txnogdcrc = 1'b0;
    repeat (3) tick();

    // Soft reset in the middle of the second GoodCRC wait, timer at 500.
    tx0 = n_tx;
    bus.r_retry = 2'd1;
    bus.r_txreq = 1'b1;
    tick();
    bus.r_txreq = 1'b0;
    wait_evt("srst_tx1", 0, tx0 + 1, 20);
    bus.ptx_ack = 1'b1;
    tick();
    bus.ptx_ack = 1'b0;
    wait_evt("srst_tx2", 0, tx0 + 2, CRCTO + 20);
    bus.ptx_ack = 1'b1;
    tick();
    bus.ptx_ack = 1'b0;
    repeat (199) tick();
    check_val("srst_pre_fsm", bus.sch_fsm, 4);
    check_val("srst_pre_retrycnt", bus.sch_retrycnt, 1);
    st  = n_done + n_fail + n_disc;
    tx0 = n_tx;
    srst = 1'b1;
    tick();
    check_val("srst_fsm", bus.sch_fsm, 0);
    check_val("srst_busy", bus.sch_busy, 0);
    check_val("srst_retrycnt", bus.sch_retrycnt, 0);
    check_val("srst_outs", {bus.sch_txreq, bus.sch_sel, bus.sch_txdone, bus.sch_txfail, bus.sch_txdisc}, 0);
    srst = 1'b0;
    repeat (CRCTO + 10) tick();
    check_val("srst_nostatus", n_done + n_fail + n_disc - st, 0);
    check_val("srst_notx", n_tx - tx0, 0);
    run_txn("srst_fresh", 0, 0, 0, 0, 1, 20);

    // Randomized transactions.
    for (int t = 0; t < 10; t++) begin
      rt = $urandom_range(3, 0);
      md = $urandom_range(3, 0);
      run_txn($sformatf("rnd%0d", t), rt, md,
              (md == 0 || md == 2) ? $urandom_range(rt, 0) : 0,
              $urandom_range(3, 0), $urandom_range(4, 0), $urandom_range(CRCTO, 1));
      repeat ($urandom_range(3, 0)) tick();
    end

    check_val("pulse_width", n_wide, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
